// File: rtl/serial_comma_aligner.sv
// Serial 8b/10b comma aligner: hunts for K28.5, locks the 10-bit boundary and emits aligned code groups.
// Optional: define COMMA_BOTH_POL_EN to also accept the RD+ K28.5 pattern.
module serial_comma_aligner #(
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned ERR_LIMIT  = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enb,
  input  logic       serialIn,
  output logic [9:0] dataOut,
  output logic       validOut,
  output logic       commaDet,
  output logic       locked,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    ST_HUNT   = 2'b00,
    ST_SYNC   = 2'b01,
    ST_LOCKED = 2'b10
  } state_e;

  localparam logic [9:0] K28P5_RDN   = 10'b0011111010;
  localparam logic [9:0] K28P5_RDP   = 10'b1100000101;
  localparam logic [3:0] LOCK_CNT_C  = 4'(LOCK_COUNT);
  localparam logic [3:0] ERR_LIMIT_C = 4'(ERR_LIMIT);

  function automatic logic is_comma(input logic [9:0] w);
`ifdef COMMA_BOTH_POL_EN
    is_comma = (w == K28P5_RDN) || (w == K28P5_RDP);
`else
    is_comma = (w == K28P5_RDN);
`endif
  endfunction

  logic [8:0] sr_q, sr_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [3:0] comma_cnt_q, comma_cnt_d;
  logic [3:0] err_cnt_q, err_cnt_d;
  state_e     state_q, state_d;
  logic [9:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       comma_det_q, comma_det_d;
  logic       locked_q, locked_d;

  logic [9:0] window_s;
  logic       comma_s;
  logic       boundary_s;

  // Next-state logic: window shift, boundary counter, lock state machine and output strobes.
  always_comb begin
    window_s    = {sr_q, serialIn};
    comma_s     = is_comma(window_s);
    boundary_s  = (bit_cnt_q == 4'd9);
    sr_d        = sr_q;
    bit_cnt_d   = bit_cnt_q;
    comma_cnt_d = comma_cnt_q;
    err_cnt_d   = err_cnt_q;
    state_d     = state_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    comma_det_d = 1'b0;

    if (enb) begin
      sr_d        = window_s;
      comma_det_d = comma_s;
      bit_cnt_d   = boundary_s ? 4'd0 : bit_cnt_q + 4'd1;
      case (state_q)
        ST_HUNT: begin
          if (comma_s) begin
            bit_cnt_d   = 4'd0;
            data_d      = window_s;
            valid_d     = 1'b1;
            comma_cnt_d = 4'd1;
            if (LOCK_CNT_C <= 4'd1) begin
              state_d   = ST_LOCKED;
              err_cnt_d = 4'd0;
            end else begin
              state_d   = ST_SYNC;
            end
          end else begin
            state_d = ST_HUNT;
          end
        end
        ST_SYNC: begin
          if (comma_s && !boundary_s) begin
            // Comma off the current boundary: restart the count on the new phase.
            bit_cnt_d   = 4'd0;
            data_d      = window_s;
            valid_d     = 1'b1;
            comma_cnt_d = 4'd1;
          end else if (boundary_s) begin
            data_d  = window_s;
            valid_d = 1'b1;
            if (comma_s) begin
              comma_cnt_d = comma_cnt_q + 4'd1;
              if ((comma_cnt_q + 4'd1) >= LOCK_CNT_C) begin
                state_d   = ST_LOCKED;
                err_cnt_d = 4'd0;
              end else begin
                state_d   = ST_SYNC;
              end
            end else begin
              comma_cnt_d = comma_cnt_q;
            end
          end else begin
            state_d = ST_SYNC;
          end
        end
        ST_LOCKED: begin
          if (boundary_s) begin
            data_d  = window_s;
            valid_d = 1'b1;
            if (comma_s) begin
              err_cnt_d = 4'd0;
            end else begin
              err_cnt_d = err_cnt_q;
            end
          end else if (comma_s) begin
            if ((err_cnt_q + 4'd1) >= ERR_LIMIT_C) begin
              bit_cnt_d   = 4'd0;
              data_d      = window_s;
              valid_d     = 1'b1;
              comma_cnt_d = 4'd1;
              err_cnt_d   = 4'd0;
              state_d     = ST_SYNC;
            end else begin
              err_cnt_d   = err_cnt_q + 4'd1;
            end
          end else begin
            state_d = ST_LOCKED;
          end
        end
        default: begin
          state_d = ST_HUNT;
        end
      endcase
    end else begin
      sr_d = sr_q;
    end

    locked_d = (state_d == ST_LOCKED);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q        <= 9'd0;
      bit_cnt_q   <= 4'd0;
      comma_cnt_q <= 4'd0;
      err_cnt_q   <= 4'd0;
      state_q     <= ST_HUNT;
      data_q      <= 10'h000;
      valid_q     <= 1'b0;
      comma_det_q <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      sr_q        <= sr_d;
      bit_cnt_q   <= bit_cnt_d;
      comma_cnt_q <= comma_cnt_d;
      err_cnt_q   <= err_cnt_d;
      state_q     <= state_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      comma_det_q <= comma_det_d;
      locked_q    <= locked_d;
    end
  end

  assign dataOut  = data_q;
  assign validOut = valid_q;
  assign commaDet = comma_det_q;
  assign locked   = locked_q;
  assign state    = state_q;

endmodule

// File: tb/tb_serial_comma_aligner.sv
// Scoreboard bench for serial_comma_aligner: expected code groups are queued as bits are sent
// and compared whenever validOut fires.
module tb_serial_comma_aligner;

  localparam logic [9:0] COMMA = 10'b0011111010;
  localparam logic [9:0] RDP   = 10'b1100000101;
  localparam logic [9:0] DGRP  = 10'b1001110100;

  logic       clk = 1'b0;
  logic       rst;
  logic       enb;
  logic       serialIn;
  logic [9:0] dataOut;
  logic       validOut;
  logic       commaDet;
  logic       locked;
  logic [1:0] state;

  int checks   = 0;
  int failures = 0;
  logic [9:0] sb_q[$];

  serial_comma_aligner dut (
    .clk      (clk),
    .rst      (rst),
    .enb      (enb),
    .serialIn (serialIn),
    .dataOut  (dataOut),
    .validOut (validOut),
    .commaDet (commaDet),
    .locked   (locked),
    .state    (state)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: drive a bit, then compare any emitted group against the scoreboard.
  task automatic tick(input logic b, input logic en);
    logic [9:0] exp10;
    serialIn = b;
    enb      = en;
    @(posedge clk);
    #1;
    if (validOut === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk_eq("unexpected_valid", 32'(validOut), 32'd0);
      end else begin
        exp10 = sb_q.pop_front();
        chk_eq("dataOut", 32'(dataOut), 32'(exp10));
      end
    end
  endtask

  task automatic send_word(input logic [9:0] w);
    for (int i = 9; i >= 0; i--) tick(w[i], 1'b1);
  endtask

  initial begin
    rst = 1'b1;
    serialIn = 1'b0;
    enb = 1'b0;
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    chk_eq("rst_state", 32'(state), 32'd0);
    chk_eq("rst_data", 32'(dataOut), 32'd0);
    chk_eq("rst_valid", 32'(validOut), 32'd0);
    chk_eq("rst_comma", 32'(commaDet), 32'd0);
    chk_eq("rst_locked", 32'(locked), 32'd0);
    rst = 1'b0;

    // Idle zeros never produce a group.
    repeat (50) tick(1'b0, 1'b1);
    chk_eq("idle_state", 32'(state), 32'd0);
    chk_eq("idle_data", 32'(dataOut), 32'd0);

    // Random phase, then the first comma and a data group.
    repeat (3) tick(1'($urandom_range(1, 0)), 1'b1);
    sb_q.push_back(COMMA);
    send_word(COMMA);
    chk_eq("hunt_valid", 32'(validOut), 32'd1);
    chk_eq("hunt_comma", 32'(commaDet), 32'd1);
    chk_eq("hunt_state", 32'(state), 32'd1);
    chk_eq("hunt_locked", 32'(locked), 32'd0);
    sb_q.push_back(DGRP);
    send_word(DGRP);
    chk_eq("sync_dvalid", 32'(validOut), 32'd1);
    chk_eq("sync_dcomma", 32'(commaDet), 32'd0);

    // Aligned commas 2..4 bring the block to LOCKED.
    for (int k = 2; k <= 4; k++) begin
      sb_q.push_back(COMMA);
      send_word(COMMA);
      chk_eq("lock_comma", 32'(commaDet), 32'd1);
      if (k < 4) begin
        chk_eq("lock_early_locked", 32'(locked), 32'd0);
        chk_eq("lock_early_state", 32'(state), 32'd1);
        sb_q.push_back(DGRP);
        send_word(DGRP);
      end else begin
        chk_eq("lock_locked", 32'(locked), 32'd1);
        chk_eq("lock_state", 32'(state), 32'd2);
      end
    end

    // Three commas shifted by two bits force a realign.
    sb_q.push_back(DGRP);
    send_word(DGRP);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    for (int e = 1; e <= 3; e++) begin
      sb_q.push_back((e == 1) ? 10'h03E : 10'h23E);
      if (e == 3) sb_q.push_back(COMMA);
      send_word(COMMA);
      chk_eq("mis_comma", 32'(commaDet), 32'd1);
      if (e < 3) begin
        chk_eq("mis_locked", 32'(locked), 32'd1);
        chk_eq("mis_state", 32'(state), 32'd2);
        chk_eq("mis_valid", 32'(validOut), 32'd0);
      end else begin
        chk_eq("realign_locked", 32'(locked), 32'd0);
        chk_eq("realign_state", 32'(state), 32'd1);
        chk_eq("realign_valid", 32'(validOut), 32'd1);
      end
    end
    sb_q.push_back(DGRP);
    send_word(DGRP);
    chk_eq("realign_next_valid", 32'(validOut), 32'd1);

    // Relock on the new phase.
    for (int k = 1; k <= 3; k++) begin
      sb_q.push_back(COMMA);
      send_word(COMMA);
      if (k == 3) chk_eq("relock_state", 32'(state), 32'd2);
      sb_q.push_back(DGRP);
      send_word(DGRP);
    end

    // Enable gap mid-group: nothing moves, boundary resumes.
    sb_q.push_back(DGRP);
    for (int i = 9; i >= 5; i--) tick(DGRP[i], 1'b1);
    repeat (7) begin
      tick(1'($urandom_range(1, 0)), 1'b0);
      chk_eq("gap_valid", 32'(validOut), 32'd0);
      chk_eq("gap_comma", 32'(commaDet), 32'd0);
      chk_eq("gap_state", 32'(state), 32'd2);
    end
    for (int i = 4; i >= 0; i--) tick(DGRP[i], 1'b1);
    chk_eq("gap_resume_valid", 32'(validOut), 32'd1);

    // Reset mid-group discards the partial word.
    for (int i = 9; i >= 6; i--) tick(DGRP[i], 1'b1);
    rst = 1'b1;
    tick(DGRP[5], 1'b1);
    rst = 1'b0;
    chk_eq("midrst_state", 32'(state), 32'd0);
    chk_eq("midrst_locked", 32'(locked), 32'd0);
    chk_eq("midrst_data", 32'(dataOut), 32'd0);
    chk_eq("midrst_valid", 32'(validOut), 32'd0);
    for (int i = 4; i >= 0; i--) tick(DGRP[i], 1'b1);
    chk_eq("midrst_hunt", 32'(state), 32'd0);

    // RD+ comma in HUNT.
`ifdef COMMA_BOTH_POL_EN
    sb_q.push_back(RDP);
    send_word(RDP);
    chk_eq("rdp_comma", 32'(commaDet), 32'd1);
    chk_eq("rdp_state", 32'(state), 32'd1);
    chk_eq("rdp_data", 32'(dataOut), 32'h305);
`else
    send_word(RDP);
    chk_eq("rdp_comma", 32'(commaDet), 32'd0);
    chk_eq("rdp_state", 32'(state), 32'd0);
    chk_eq("rdp_valid", 32'(validOut), 32'd0);
`endif

    chk_eq("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
